// File: rtl/ex_mem_ft_stage.sv
// EX/MEM pipeline register behind the TMR ALU voter: retries a computation on voter
// disagreement and latches a sticky fatal state after MAX_RETRY failed retries.
// Optional error counter: define FT_ERR_COUNT_EN to implement err_count.
module ex_mem_ft_stage #(
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    input  logic             error_flag,
    input  logic [4:0]       rd_in,
    input  logic             reg_write_in,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic [31:0]      store_data_in,
    input  logic             flush,
    input  logic             mem_stall,
    output logic             out_valid,
    output logic [31:0]      alu_result_q,
    output logic [31:0]      store_data_q,
    output logic             alu_zero_q,
    output logic [4:0]       rd_q,
    output logic             reg_write_q,
    output logic             mem_read_q,
    output logic             mem_write_q,
    output logic             stall_ex,
    output logic             fatal_error,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_PASS  = 2'd0,
        ST_RETRY = 2'd1,
        ST_FATAL = 2'd2
    } state_t;

    localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [2:0]  retry_q, retry_d;
    logic        valid_q, valid_d;
    logic [31:0] result_q, result_d;
    logic [31:0] sdata_q, sdata_d;
    logic        zero_q, zero_d;
    logic [4:0]  dest_q, dest_d;
    logic        ctl_rw_q, ctl_rw_d;
    logic        ctl_mr_q, ctl_mr_d;
    logic        ctl_mw_q, ctl_mw_d;
    logic        fatal_q, fatal_d;
    logic        stall_s;
    logic        err_inc_s;

    // Next-state and stall decision; data fields are only reloaded on a clean accept.
    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        valid_d   = valid_q;
        result_d  = result_q;
        sdata_d   = sdata_q;
        zero_d    = zero_q;
        dest_d    = dest_q;
        ctl_rw_d  = ctl_rw_q;
        ctl_mr_d  = ctl_mr_q;
        ctl_mw_d  = ctl_mw_q;
        fatal_d   = fatal_q;
        stall_s   = 1'b0;
        err_inc_s = 1'b0;
        case (state_q)
            ST_PASS, ST_RETRY: begin
                if (mem_stall) begin
                    stall_s = 1'b1;
                end else if (flush) begin
                    valid_d  = 1'b0;
                    ctl_rw_d = 1'b0;
                    ctl_mr_d = 1'b0;
                    ctl_mw_d = 1'b0;
                    state_d  = ST_PASS;
                    retry_d  = 3'd0;
                end else if (in_valid) begin
                    if (!error_flag) begin
                        valid_d  = 1'b1;
                        result_d = alu_result;
                        sdata_d  = store_data_in;
                        zero_d   = alu_zero;
                        dest_d   = rd_in;
                        ctl_rw_d = reg_write_in;
                        ctl_mr_d = mem_read_in;
                        ctl_mw_d = mem_write_in;
                        state_d  = ST_PASS;
                        retry_d  = 3'd0;
                    end else begin
                        // Faulty compute: hold ID/EX so the same operands are re-voted.
                        valid_d   = 1'b0;
                        ctl_rw_d  = 1'b0;
                        ctl_mr_d  = 1'b0;
                        ctl_mw_d  = 1'b0;
                        stall_s   = 1'b1;
                        err_inc_s = 1'b1;
                        if (retry_q < MAX_R) begin
                            retry_d = retry_q + 3'd1;
                            state_d = ST_RETRY;
                        end else begin
                            state_d = ST_FATAL;
                            fatal_d = 1'b1;
                        end
                    end
                end else begin
                    valid_d  = 1'b0;
                    ctl_rw_d = 1'b0;
                    ctl_mr_d = 1'b0;
                    ctl_mw_d = 1'b0;
                end
            end
            ST_FATAL: begin
                stall_s  = 1'b1;
                valid_d  = 1'b0;
                ctl_rw_d = 1'b0;
                ctl_mr_d = 1'b0;
                ctl_mw_d = 1'b0;
                fatal_d  = 1'b1;
            end
            default: begin
                stall_s  = 1'b1;
                valid_d  = 1'b0;
                ctl_rw_d = 1'b0;
                ctl_mr_d = 1'b0;
                ctl_mw_d = 1'b0;
                fatal_d  = 1'b1;
                state_d  = ST_FATAL;
            end
        endcase
    end

    // FSM, retry counter and EX/MEM register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_PASS;
            retry_q  <= 3'd0;
            valid_q  <= 1'b0;
            result_q <= 32'd0;
            sdata_q  <= 32'd0;
            zero_q   <= 1'b0;
            dest_q   <= 5'd0;
            ctl_rw_q <= 1'b0;
            ctl_mr_q <= 1'b0;
            ctl_mw_q <= 1'b0;
            fatal_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            retry_q  <= retry_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            sdata_q  <= sdata_d;
            zero_q   <= zero_d;
            dest_q   <= dest_d;
            ctl_rw_q <= ctl_rw_d;
            ctl_mr_q <= ctl_mr_d;
            ctl_mw_q <= ctl_mw_d;
            fatal_q  <= fatal_d;
        end
    end

`ifdef FT_ERR_COUNT_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Saturating count of erroneous computes.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_inc_s && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= {CNT_W{1'b0}};
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    logic unused_err_inc_s;
    assign unused_err_inc_s = err_inc_s;
    assign err_count        = {CNT_W{1'b0}};
`endif

    assign out_valid    = valid_q;
    assign alu_result_q = result_q;
    assign store_data_q = sdata_q;
    assign alu_zero_q   = zero_q;
    assign rd_q         = dest_q;
    assign reg_write_q  = ctl_rw_q & valid_q;
    assign mem_read_q   = ctl_mr_q & valid_q;
    assign mem_write_q  = ctl_mw_q & valid_q;
    assign stall_ex     = stall_s;
    assign fatal_error  = fatal_q;

endmodule
